// File: rtl/sequence_generator_tx.sv
//------------------------------------------------------------------------------
// Module   : sequence_generator_tx
// Purpose  : Serial pattern transmitter, MSB first, programmable frame count
//            and inter-frame gap, with start/busy/done handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sequence_generator_tx #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_end,
  output logic             busy,
  output logic             done
);

  localparam int                 c_IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [c_IDX_W-1:0] c_MSB_IDX = c_IDX_W'(PAT_W - 1);
  localparam logic               c_ONE_BIT = (PAT_W == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_GAP  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_IDX_W-1:0] r_bit_idx, w_bit_idx_nxt;
  logic [CNT_W-1:0]   r_frames_left, w_frames_nxt;
  logic [CNT_W-1:0]   r_rep_cnt, w_rep_nxt;
  logic [GAP_W-1:0]   r_gap_len, w_gap_len_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic               r_stop_seen, w_stop_nxt;
  logic               r_serial, w_serial_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_fend, w_fend_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               w_stop_any;
  logic               w_last_frame;

  assign w_stop_any   = r_stop_seen | stop;
  assign w_last_frame = w_stop_any |
                        ((r_rep_cnt != '0) && (r_frames_left == CNT_W'(1)));

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_frames_nxt  = r_frames_left;
    w_rep_nxt     = r_rep_cnt;
    w_gap_len_nxt = r_gap_len;
    w_gap_cnt_nxt = r_gap_cnt;
    w_stop_nxt    = r_stop_seen;
    w_serial_nxt  = 1'b0;
    w_valid_nxt   = 1'b0;
    w_fend_nxt    = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_stop_nxt = 1'b0;
        if (start) begin
          w_rep_nxt     = repeat_cnt;
          w_gap_len_nxt = gap_len;
          w_frames_nxt  = repeat_cnt;
          w_bit_idx_nxt = c_MSB_IDX;
          w_serial_nxt  = PATTERN[PAT_W-1];
          w_valid_nxt   = 1'b1;
          w_fend_nxt    = c_ONE_BIT;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_SEND;
        end
      end

      S_SEND: begin
        w_stop_nxt = w_stop_any;
        if (r_bit_idx != '0) begin
          w_bit_idx_nxt = r_bit_idx - c_IDX_W'(1);
          w_serial_nxt  = PATTERN[w_bit_idx_nxt];
          w_valid_nxt   = 1'b1;
          w_fend_nxt    = (w_bit_idx_nxt == '0);
          w_busy_nxt    = 1'b1;
        end else begin
          // Frame boundary: count it, then decide between stop, restart or gap.
          if (r_rep_cnt != '0) begin
            w_frames_nxt = r_frames_left - CNT_W'(1);
          end
          if (w_last_frame) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else if (r_gap_len == '0) begin
            w_bit_idx_nxt = c_MSB_IDX;
            w_serial_nxt  = PATTERN[PAT_W-1];
            w_valid_nxt   = 1'b1;
            w_fend_nxt    = c_ONE_BIT;
            w_busy_nxt    = 1'b1;
          end else begin
            w_gap_cnt_nxt = r_gap_len;
            w_busy_nxt    = 1'b1;
            w_state_nxt   = S_GAP;
          end
        end
      end

      S_GAP: begin
        w_stop_nxt = w_stop_any;
        if (w_stop_any) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_gap_cnt <= GAP_W'(1)) begin
          w_bit_idx_nxt = c_MSB_IDX;
          w_serial_nxt  = PATTERN[PAT_W-1];
          w_valid_nxt   = 1'b1;
          w_fend_nxt    = c_ONE_BIT;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_SEND;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
          w_busy_nxt    = 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_bit_idx     <= '0;
      r_frames_left <= '0;
      r_rep_cnt     <= '0;
      r_gap_len     <= '0;
      r_gap_cnt     <= '0;
      r_stop_seen   <= 1'b0;
      r_serial      <= 1'b0;
      r_valid       <= 1'b0;
      r_fend        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_idx     <= w_bit_idx_nxt;
      r_frames_left <= w_frames_nxt;
      r_rep_cnt     <= w_rep_nxt;
      r_gap_len     <= w_gap_len_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_stop_seen   <= w_stop_nxt;
      r_serial      <= w_serial_nxt;
      r_valid       <= w_valid_nxt;
      r_fend        <= w_fend_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign serial_out = r_serial;
  assign bit_valid  = r_valid;
  assign frame_end  = r_fend;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

`default_nettype wire
